reg_display_driver: RTL and testbench

- Downstream consumer of the single-cycle CPU's register-display path.
- Drives the register-select index into the register file's display read port.
- Captures the returned 32-bit value once per scan frame and shows one 16-bit half on a 4-digit, active-low, multiplexed 7-segment display.
- A debounced push-button toggles between the lower and upper halves.

---
 rtl/reg_display_driver.sv | 130 +++++++++++++
 tb/tb_reg_display_driver.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reg_display_driver.sv
// Register-display front end: drives the register index to the register file, latches its value once per
// scan frame, and multiplexes one 16-bit half onto a 4-digit active-low 7-segment display.
module reg_display_driver #(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sw_reg_sel,
  input  logic        btn_half,
  input  logic [31:0] display_data,
  output logic [4:0]  display_reg,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] REF_TC  = RW'(REFRESH_DIV - 1);
  // Accept on the edge where the count reaches DEBOUNCE_CYCLES-1.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING} btn_state_e;

  logic [4:0]    display_reg_q;
  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [31:0]   data_latch_q, data_latch_d;
  logic          half_sel_q, half_sel_d;
  btn_state_e    state_q, state_d;
  logic [DW-1:0] debounce_cnt_q, debounce_cnt_d;
  logic [1:0]    sync_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          refresh_tc, btn_s;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'b1000000;  4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;  4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;  4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;  4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;  4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;  4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;  4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;  default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign btn_s = sync_q[1];

  always_comb begin
    refresh_tc     = (refresh_cnt_q == REF_TC);
    refresh_cnt_d  = refresh_tc ? '0 : refresh_cnt_q + RW'(1);
    digit_idx_d    = refresh_tc ? digit_idx_q + 2'd1 : digit_idx_q;
    // Capture only at the frame boundary so a frame never mixes two values.
    data_latch_d   = (refresh_tc && digit_idx_q == 2'd3) ? display_data : data_latch_q;
    nibble         = data_latch_q[{half_sel_q, digit_idx_q, 2'b00} +: 4];
    an_d           = ~(4'b0001 << digit_idx_q);
    seg_d          = hex_to_seg(nibble);
    dp_d           = ~(half_sel_q && digit_idx_q == 2'd3);
  end

  always_comb begin
    state_d        = state_q;
    debounce_cnt_d = debounce_cnt_q;
    half_sel_d     = half_sel_q;
    case (state_q)
      RELEASED: if (btn_s) begin
        state_d        = PRESS_PENDING;
        debounce_cnt_d = '0;
      end
      PRESS_PENDING: if (!btn_s) begin
        state_d = RELEASED;
      end else begin
        debounce_cnt_d = debounce_cnt_q + DW'(1);
        if (debounce_cnt_q == DB_LAST) begin
          state_d    = PRESSED;
          half_sel_d = ~half_sel_q;
        end
      end
      PRESSED: if (!btn_s) begin
        state_d        = RELEASE_PENDING;
        debounce_cnt_d = '0;
      end
      RELEASE_PENDING: if (btn_s) begin
        state_d = PRESSED;
      end else begin
        debounce_cnt_d = debounce_cnt_q + DW'(1);
        if (debounce_cnt_q == DB_LAST) state_d = RELEASED;
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      display_reg_q  <= '0;
      refresh_cnt_q  <= '0;
      digit_idx_q    <= '0;
      data_latch_q   <= '0;
      half_sel_q     <= 1'b0;
      state_q        <= RELEASED;
      debounce_cnt_q <= '0;
      sync_q         <= '0;
      an_q           <= 4'b1111;
      seg_q          <= 7'b1111111;
      dp_q           <= 1'b1;
    end else begin
      display_reg_q  <= sw_reg_sel;
      refresh_cnt_q  <= refresh_cnt_d;
      digit_idx_q    <= digit_idx_d;
      data_latch_q   <= data_latch_d;
      half_sel_q     <= half_sel_d;
      state_q        <= state_d;
      debounce_cnt_q <= debounce_cnt_d;
      sync_q         <= {sync_q[0], btn_half};
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign display_reg = display_reg_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
endmodule

// File: tb/tb_reg_display_driver.sv
// Scoreboarded bench: the stimulus loop pushes each frame's expected digits; a negedge monitor pops one
// entry whenever a new digit is lit (anode change) and compares it.
module tb_reg_display_driver;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  sw_reg_sel;
  logic        btn_half;
  logic [31:0] display_data;
  logic [4:0]  display_reg;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  reg_display_driver #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .sw_reg_sel(sw_reg_sel), .btn_half(btn_half),
    .display_data(display_data), .display_reg(display_reg), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] an; logic [6:0] seg; logic dp; } disp_t;
  disp_t exp_q[$];
  disp_t exp_e;
  int    checks = 0;
  int    failures = 0;
  int    pos = 0;
  int    evt = 0;
  bit    mon_en = 1'b0;
  logic [3:0] prev_an = 4'b1111;

  logic [6:0] seg_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  // Frame f covers positions 16f..16f+15; value shown is the one captured at the end of frame f-1.
  logic [31:0] fval [13] = '{32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 32'h12345678,
                             32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
  bit fhalf [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int f);
    logic [31:0] v;
    disp_t d;
    v = fval[f];
    for (int k = 0; k < 4; k++) begin
      d.an  = ~(4'b0001 << k);
      d.seg = seg_tbl[v[16*int'(fhalf[f]) + 4*k +: 4]];
      d.dp  = !(k == 3 && fhalf[f]);
      exp_q.push_back(d);
    end
  endtask

  task automatic go(input int p);
    while (pos < p) begin
      @(posedge clk); #1;
      pos++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && an !== prev_an) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_digit", {20'h0, an, seg, dp}, 32'h0);
      end else begin
        exp_e = exp_q.pop_front();
        chk($sformatf("digit_evt%0d", evt), {20'h0, an, seg, dp}, {20'h0, exp_e});
      end
      evt <= evt + 1;
    end
    prev_an <= an;
  end

  initial begin
    rst = 1'b0;
    sw_reg_sel = 5'($urandom);
    btn_half = 1'($urandom);
    display_data = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dp", dp, 1'b1);
    chk("rst_display_reg", display_reg, 5'd0);

    sw_reg_sel = 5'd0; btn_half = 1'b0; display_data = 32'hDEAD_BEEF;
    rst = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    pos = 0;

    for (int p = 0; p <= 207; p++) begin
      go(p);
      if (p == 207) mon_en = 1'b0;
      if (p % 16 == 0) push_frame(p / 16);
      case (p)
        2:   begin chk("reg_idx_before", display_reg, 5'd0); sw_reg_sel = 5'd17; end
        3:   begin chk("reg_idx_17", display_reg, 5'd17); sw_reg_sel = 5'd3; end
        4:   chk("reg_idx_3", display_reg, 5'd3);
        37:  display_data = 32'h1234_5678;
        80:  display_data = 32'hDEAD_BEEF;
        104: begin chk("reject_half", dut.half_sel_q, 1'b0); btn_half = 1'b0; end
        112: chk("reject_half_settled", dut.half_sel_q, 1'b0);
        117: btn_half = 1'b1;
        126: chk("press1_not_yet", dut.half_sel_q, 1'b0);
        127: chk("press1_toggle", dut.half_sel_q, 1'b1);
        137: begin chk("hold_no_retoggle", dut.half_sel_q, 1'b1); btn_half = 1'b0; end
        160: chk("release_no_toggle", dut.half_sel_q, 1'b1);
        165: btn_half = 1'b1;
        174: chk("press2_not_yet", dut.half_sel_q, 1'b1);
        175: chk("press2_toggle", dut.half_sel_q, 1'b0);
        185: btn_half = 1'b0;
        default: ;
      endcase
      if (p >= 64 && p < 104 && (p - 64) % 3 == 0) btn_half = ~btn_half;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    // Mid-frame reset must drop the latched value as well as the scan position.
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst2_an", an, 4'b1111);
    chk("rst2_seg", seg, 7'b1111111);
    chk("rst2_dp", dp, 1'b1);
    chk("rst2_display_reg", display_reg, 5'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_first_an", an, 4'b1110);
    chk("rst2_first_seg", seg, 7'b1000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
